// File: rtl/bottling_controller_pkg.sv
// Shared constants for the bottling line controller: state codes, default timings and helpers.
package bottling_controller_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StMove     = 3'd1,
    StFill     = 3'd2,
    StWaitCork = 3'd3,
    StCap      = 3'd4,
    StFault    = 3'd5
  } state_e;

  localparam int unsigned TempoVedacaoDefault      = 3;
  localparam int unsigned TimeoutEnchimentoDefault = 50;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bottling_controller_if.sv
// Operator, sensor and actuator signals of one bottling station.
interface bottling_controller_if;
  logic       start;
  logic       stop;
  logic       ack_erro;
  logic       sensor_garrafa;
  logic       sensor_nivel;
  logic [7:0] rolhas_linha;
  logic       motor;
  logic       valvula;
  logic       vedacao;
  logic       done;
  logic       alarme_sem_rolha;
  logic       erro;
  logic [7:0] garrafas_ok;
  logic [2:0] estado;

  modport slave (
    input  start, stop, ack_erro, sensor_garrafa, sensor_nivel, rolhas_linha,
    output motor, valvula, vedacao, done, alarme_sem_rolha, erro, garrafas_ok, estado
  );

  modport master (
    output start, stop, ack_erro, sensor_garrafa, sensor_nivel, rolhas_linha,
    input  motor, valvula, vedacao, done, alarme_sem_rolha, erro, garrafas_ok, estado
  );
endinterface

// File: rtl/bottling_controller_cycle_timer.sv
// 8-bit clear/enable counter; tc_o flags the last enabled cycle before limit_i is reached.
module bottling_controller_cycle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] limit_i,
  output logic       tc_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (en_i && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && (count_q == limit_i - 8'd1);

endmodule

// File: rtl/bottling_controller.sv
// Bottling station sequencer: convey, fill, wait for a cork, cap, with fill-timeout fault.
module bottling_controller
  import bottling_controller_pkg::*;
#(
  parameter int unsigned TEMPO_VEDACAO      = TempoVedacaoDefault,
  parameter int unsigned TIMEOUT_ENCHIMENTO = TimeoutEnchimentoDefault
) (
  input logic                  clk,
  input logic                  reset,
  bottling_controller_if.slave bus
);

  localparam logic [7:0] CapLimit  = 8'(TEMPO_VEDACAO);
  localparam logic [7:0] FillLimit = 8'(TIMEOUT_ENCHIMENTO);

  state_e     st_q, st_d;
  logic       stop_pend_q, stop_pend_d;
  logic       motor_q, valvula_q, vedacao_q, alarme_q, erro_q, done_q;
  logic [7:0] garrafas_q, garrafas_d;
  logic       fill_tc, cap_tc, cap_exit;
  logic       has_cork;

  assign has_cork = (bus.rolhas_linha != 8'd0);

  bottling_controller_cycle_timer u_fill_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (st_q != StFill),
    .en_i    (st_q == StFill),
    .limit_i (FillLimit),
    .tc_o    (fill_tc)
  );

  bottling_controller_cycle_timer u_cap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (st_q != StCap),
    .en_i    (st_q == StCap),
    .limit_i (CapLimit),
    .tc_o    (cap_tc)
  );

  always_comb begin
    st_d        = st_q;
    stop_pend_d = stop_pend_q;
    cap_exit    = 1'b0;
    case (st_q)
      StIdle: if (bus.start && !bus.stop) st_d = StMove;
      StMove: begin
        if (bus.stop) st_d = StIdle;
        else if (bus.sensor_garrafa) st_d = StFill;
      end
      StFill: begin
        if (bus.stop) stop_pend_d = 1'b1;
        // Level reached wins over a timeout landing in the same cycle.
        if (bus.sensor_nivel) st_d = has_cork ? StCap : StWaitCork;
        else if (fill_tc) st_d = StFault;
      end
      StWaitCork: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (has_cork) st_d = StCap;
      end
      StCap: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (cap_tc) begin
          cap_exit = 1'b1;
          st_d     = (stop_pend_q || bus.stop) ? StIdle : StMove;
        end
      end
      StFault: if (bus.ack_erro) st_d = StIdle;
      default: st_d = StIdle;
    endcase
    if (st_d == StIdle) stop_pend_d = 1'b0;
    garrafas_d = cap_exit ? sat_inc8(garrafas_q) : garrafas_q;
  end

  // Actuator flags are registered from the next state so they line up with estado.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= StIdle;
      stop_pend_q <= 1'b0;
      motor_q     <= 1'b0;
      valvula_q   <= 1'b0;
      vedacao_q   <= 1'b0;
      alarme_q    <= 1'b0;
      erro_q      <= 1'b0;
      done_q      <= 1'b0;
      garrafas_q  <= 8'd0;
    end else begin
      st_q        <= st_d;
      stop_pend_q <= stop_pend_d;
      motor_q     <= (st_d == StMove);
      valvula_q   <= (st_d == StFill);
      vedacao_q   <= (st_d == StCap);
      alarme_q    <= (st_d == StWaitCork);
      erro_q      <= (st_d == StFault);
      done_q      <= cap_exit;
      garrafas_q  <= garrafas_d;
    end
  end

  assign bus.motor            = motor_q;
  assign bus.valvula          = valvula_q;
  assign bus.vedacao          = vedacao_q;
  assign bus.alarme_sem_rolha = alarme_q;
  assign bus.erro             = erro_q;
  assign bus.done             = done_q;
  assign bus.garrafas_ok      = garrafas_q;
  assign bus.estado           = st_q;

endmodule

// File: tb/tb_bottling_controller.sv
// Scenario bench for bottling_controller with a bottle-level reference model.
module tb_bottling_controller;
  import bottling_controller_pkg::*;

  localparam int TV = TempoVedacaoDefault;
  localparam int TE = TimeoutEnchimentoDefault;

  logic clk;
  logic reset;
  bottling_controller_if bus ();

  int checks = 0;
  int errors = 0;
  int exp_ok = 0;

  bottling_controller #(
    .TEMPO_VEDACAO      (TV),
    .TIMEOUT_ENCHIMENTO (TE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    tick();
    exp_ok = 0;
  endtask

  task automatic go_move();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.estado !== 3'(StMove) || bus.motor !== 1'b1) begin
      errors++;
      $display("FAIL start_to_move: estado=%0d motor=%b, want 1/1", bus.estado, bus.motor);
    end
  endtask

  // One bottle from MOVE through capping; expected outcome derived from the bottle rules.
  task automatic run_bottle(input int move_wait, input int fill_len, input logic [7:0] corks,
                            input int cork_wait, input int stop_at);
    int vcount, dones, n;
    logic [2:0] exp_st;
    repeat (move_wait) tick();
    checks++;
    if (bus.estado !== 3'(StMove) || bus.motor !== 1'b1) begin
      errors++;
      $display("FAIL move_hold: estado=%0d motor=%b, want 1/1", bus.estado, bus.motor);
    end
    bus.sensor_garrafa = 1'b1;
    tick();
    bus.sensor_garrafa = 1'b0;
    checks++;
    if (bus.estado !== 3'(StFill) || bus.valvula !== 1'b1 || bus.motor !== 1'b0) begin
      errors++;
      $display("FAIL fill_entry: estado=%0d valvula=%b motor=%b, want 2/1/0",
               bus.estado, bus.valvula, bus.motor);
    end
    for (int k = 0; k < fill_len; k++) begin
      bus.stop  = (k == stop_at);
      bus.start = 1'($urandom_range(0, 1));
      tick();
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    bus.rolhas_linha = corks;
    bus.sensor_nivel = 1'b1;
    tick();
    bus.sensor_nivel = 1'b0;
    dones = 0;
    if (corks == 8'd0) begin
      checks++;
      if (bus.estado !== 3'(StWaitCork) || bus.alarme_sem_rolha !== 1'b1 ||
          {bus.motor, bus.valvula, bus.vedacao} !== 3'b000) begin
        errors++;
        $display("FAIL wait_cork: estado=%0d alarme=%b act=%b%b%b, want 3/1/000", bus.estado,
                 bus.alarme_sem_rolha, bus.motor, bus.valvula, bus.vedacao);
      end
      repeat (cork_wait) begin
        tick();
        if (bus.done) dones++;
      end
      bus.rolhas_linha = 8'd15;
      tick();
    end
    checks++;
    if (bus.estado !== 3'(StCap) || bus.vedacao !== 1'b1 || bus.valvula !== 1'b0) begin
      errors++;
      $display("FAIL cap_entry: estado=%0d vedacao=%b valvula=%b, want 4/1/0",
               bus.estado, bus.vedacao, bus.valvula);
    end
    vcount = 1;
    n = 0;
    while (bus.estado === 3'(StCap) && n < 40) begin
      tick();
      n++;
      if (bus.vedacao) vcount++;
      if (bus.done) dones++;
    end
    exp_ok = sat(exp_ok);
    exp_st = (stop_at >= 0) ? 3'(StIdle) : 3'(StMove);
    checks++;
    if (vcount != TV || dones != 1) begin
      errors++;
      $display("FAIL cap_hold: vedacao cycles=%0d dones=%0d, want %0d/1", vcount, dones, TV);
    end
    checks++;
    if (bus.garrafas_ok !== 8'(exp_ok) || bus.estado !== exp_st) begin
      errors++;
      $display("FAIL cap_exit: garrafas_ok=%0d estado=%0d, want %0d/%0d",
               bus.garrafas_ok, bus.estado, exp_ok, exp_st);
    end
    bus.rolhas_linha = 8'd10;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.estado !== exp_st) begin
      errors++;
      $display("FAIL done_single: done=%b estado=%0d, want 0/%0d", bus.done, bus.estado, exp_st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.motor, bus.valvula, bus.vedacao, bus.done, bus.alarme_sem_rolha, bus.erro} !== 6'b0
        || bus.garrafas_ok !== 8'd0 || bus.estado !== 3'(StIdle)) begin
      errors++;
      $display("FAIL reset_state: outs=%b%b%b%b%b%b cnt=%0d estado=%0d, want all 0",
               bus.motor, bus.valvula, bus.vedacao, bus.done, bus.alarme_sem_rolha, bus.erro,
               bus.garrafas_ok, bus.estado);
    end
    #1 reset = 1'b0;
    tick();
    exp_ok = 0;
  endtask

  task automatic test_normal();
    go_move();
    run_bottle(3, 5, 8'd10, 0, -1);
  endtask

  task automatic test_no_cork();
    run_bottle(1, 3, 8'd0, 4, -1);
  endtask

  task automatic test_stop_in_fill();
    run_bottle(0, 6, 8'd10, 0, 2);
  endtask

  task automatic test_stop_in_move();
    go_move();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checks++;
    if (bus.estado !== 3'(StIdle) || bus.motor !== 1'b0) begin
      errors++;
      $display("FAIL stop_in_move: estado=%0d motor=%b, want 0/0", bus.estado, bus.motor);
    end
  endtask

  task automatic test_start_stop();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (bus.estado !== 3'(StIdle) || bus.motor !== 1'b0) begin
        errors++;
        $display("FAIL start_with_stop: estado=%0d motor=%b, want 0/0", bus.estado, bus.motor);
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic test_timeout();
    int n, dones;
    go_move();
    bus.sensor_garrafa = 1'b1;
    tick();
    bus.sensor_garrafa = 1'b0;
    n = 0;
    dones = 0;
    while (bus.estado !== 3'(StFault) && n < 300) begin
      tick();
      n++;
      if (bus.done) dones++;
    end
    checks++;
    if (n != TE || bus.erro !== 1'b1 || dones != 0 || bus.valvula !== 1'b0) begin
      errors++;
      $display("FAIL fill_timeout: cycles=%0d erro=%b dones=%0d valvula=%b, want %0d/1/0/0",
               n, bus.erro, dones, bus.valvula, TE);
    end
    tick();
    checks++;
    if (bus.estado !== 3'(StFault) || bus.garrafas_ok !== 8'(exp_ok)) begin
      errors++;
      $display("FAIL fault_hold: estado=%0d garrafas_ok=%0d, want 5/%0d",
               bus.estado, bus.garrafas_ok, exp_ok);
    end
    bus.ack_erro = 1'b1;
    tick();
    bus.ack_erro = 1'b0;
    checks++;
    if (bus.estado !== 3'(StIdle) || bus.erro !== 1'b0) begin
      errors++;
      $display("FAIL fault_ack: estado=%0d erro=%b, want 0/0", bus.estado, bus.erro);
    end
  endtask

  task automatic test_level_at_timeout();
    go_move();
    run_bottle(0, TE - 1, 8'd10, 0, -1);
  endtask

  task automatic test_random();
    bit in_idle;
    int fl, sa;
    in_idle = (bus.estado === 3'(StIdle));
    for (int i = 0; i < 20; i++) begin
      if (in_idle) go_move();
      fl = $urandom_range(0, TE - 1);
      sa = ($urandom_range(0, 3) == 0 && fl > 0) ? $urandom_range(0, fl - 1) : -1;
      run_bottle($urandom_range(0, 4), fl,
                 ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                 $urandom_range(1, 4), sa);
      in_idle = (sa >= 0);
    end
    if (!in_idle) begin
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
    end
  endtask

  task automatic test_saturation();
    int n, dones;
    do_reset();
    go_move();
    dones = 0;
    for (int b = 0; b < 256; b++) begin
      bus.sensor_garrafa = 1'b1;
      tick();
      bus.sensor_garrafa = 1'b0;
      bus.sensor_nivel = 1'b1;
      tick();
      bus.sensor_nivel = 1'b0;
      n = 0;
      while (!bus.done && n < 20) begin
        tick();
        n++;
      end
      if (bus.done) dones++;
      exp_ok = sat(exp_ok);
      checks++;
      if (bus.garrafas_ok !== 8'(exp_ok)) begin
        errors++;
        $display("FAIL saturation_count: bottle %0d garrafas_ok=%0d, want %0d",
                 b, bus.garrafas_ok, exp_ok);
      end
    end
    checks++;
    if (dones != 256 || bus.garrafas_ok !== 8'd255) begin
      errors++;
      $display("FAIL saturation_end: dones=%0d garrafas_ok=%0d, want 256/255",
               dones, bus.garrafas_ok);
    end
  endtask

  task automatic test_reset_in_cap();
    bus.sensor_garrafa = 1'b1;
    tick();
    bus.sensor_garrafa = 1'b0;
    bus.rolhas_linha = 8'd10;
    bus.sensor_nivel = 1'b1;
    tick();
    bus.sensor_nivel = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.motor, bus.valvula, bus.vedacao, bus.done, bus.alarme_sem_rolha, bus.erro} !== 6'b0
        || bus.garrafas_ok !== 8'd0 || bus.estado !== 3'(StIdle)) begin
      errors++;
      $display("FAIL reset_in_cap: outs=%b%b%b%b%b%b cnt=%0d estado=%0d, want all 0",
               bus.motor, bus.valvula, bus.vedacao, bus.done, bus.alarme_sem_rolha, bus.erro,
               bus.garrafas_ok, bus.estado);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    tick();
    exp_ok = 0;
    checks++;
    if (bus.estado !== 3'(StIdle) || bus.done !== 1'b0 || bus.garrafas_ok !== 8'd0) begin
      errors++;
      $display("FAIL after_reset_release: estado=%0d done=%b cnt=%0d, want 0/0/0",
               bus.estado, bus.done, bus.garrafas_ok);
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.stop           = 1'b0;
    bus.ack_erro       = 1'b0;
    bus.sensor_garrafa = 1'b0;
    bus.sensor_nivel   = 1'b0;
    bus.rolhas_linha   = 8'd10;
    test_reset();
    test_normal();
    test_no_cork();
    test_stop_in_fill();
    test_stop_in_move();
    test_start_stop();
    test_timeout();
    test_level_at_timeout();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    test_random();
    test_saturation();
    test_reset_in_cap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bottling_controller.md
BOTTLING_CONTROLLER -- requirements
Module: bottling_controller

Interface
REQ-001 Parameter TEMPO_VEDACAO, default 3, capping actuator hold time in clk cycles (range 1..255).
REQ-002 Parameter TIMEOUT_ENCHIMENTO, default 50, maximum fill duration in clk cycles before a fault (range 1..255).
REQ-003 clk  input  1  clock, all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level or pulse; a high sample requests production start.
REQ-006 stop  input  1  level or pulse; a high sample requests production stop.
REQ-007 ack_erro  input  1  operator fault acknowledge.
REQ-008 sensor_garrafa  input  1  bottle present at the fill/cap station.
REQ-009 sensor_nivel  input  1  fill level reached.
REQ-010 rolhas_linha  input  8  unsigned count of corks available on the line, from the stock block.
REQ-011 motor  output  1  conveyor drive.
REQ-012 valvula  output  1  fill valve open.
REQ-013 vedacao  output  1  capping actuator.
REQ-014 done  output  1  one-cycle pulse per capped bottle; consumed by the stock block as a cork decrement.
REQ-015 alarme_sem_rolha  output  1  waiting for a cork.
REQ-016 erro  output  1  fill-timeout fault latched.
REQ-017 garrafas_ok  output  8  count of capped bottles.
REQ-018 estado  output  3  current FSM state encoding.

Function
REQ-019 States and encodings: IDLE=0, MOVE=1, FILL=2, WAIT_CORK=3, CAP=4, FAULT=5; codes 6 and 7 are unused and recover to IDLE on the next clock.
REQ-020 All outputs are registered and are Moore functions of the state, except done, which is a registered pulse.
REQ-021 IDLE: all actuators are 0; start=1 and stop=0 go to MOVE; start and stop both high keep the FSM in IDLE (stop wins).
REQ-022 MOVE: motor=1; stop=1 goes to IDLE; otherwise sensor_garrafa=1 goes to FILL, with motor=0 in the cycle FILL is entered.
REQ-023 FILL: valvula=1; an 8-bit timer clears on entry and increments each cycle.
REQ-024 FILL: sensor_nivel=1 goes to CAP if rolhas_linha>0, otherwise to WAIT_CORK.
REQ-025 FILL: if the timer reaches TIMEOUT_ENCHIMENTO before sensor_nivel, the FSM goes to FAULT.
REQ-026 FILL: sensor_nivel takes priority over timeout in the same cycle.
REQ-027 WAIT_CORK: all actuators are 0 and alarme_sem_rolha=1; rolhas_linha>0 goes to CAP.
REQ-028 CAP: vedacao=1 for exactly TEMPO_VEDACAO cycles, using a counter cleared on entry.
REQ-029 On leaving CAP, done=1 for exactly one cycle and garrafas_ok increments, saturating at 255.
REQ-030 On leaving CAP, the FSM goes to IDLE if a stop was latched, otherwise to MOVE.
REQ-031 stop sampled high in FILL, WAIT_CORK or CAP sets a stop_pend latch; the current bottle always completes, and the latch clears on entry to IDLE.
REQ-032 start has no effect outside IDLE.
REQ-033 FAULT: all actuators are 0 and erro=1; ack_erro=1 goes to IDLE and clears erro; no done is issued for the faulted bottle.
REQ-034 done is never asserted in two consecutive cycles, and at most one done is issued per bottle.

Reset
REQ-035 Reset sets: state=IDLE, motor=valvula=vedacao=done=0, alarme_sem_rolha=erro=0, garrafas_ok=0, both timers=0, stop_pend=0.
REQ-036 Reset asserted mid-operation (any state) aborts immediately with no done pulse; the next cycle after release is IDLE.

Structure
REQ-037 State encodings, TEMPO_VEDACAO and TIMEOUT_ENCHIMENTO defaults belong in a shared constants include used by the controller and its bench.
REQ-038 One sub-module, cycle_timer: an 8-bit clear/enable/terminal-count counter, instantiated for the fill timeout and for the cap hold.

Verification
REQ-039 Normal cycle: reset, start pulse, sensor_garrafa at cycle 4, sensor_nivel 5 cycles later, rolhas_linha=10 -> vedacao high exactly 3 cycles, then one done pulse, garrafas_ok=1, FSM back in MOVE.
REQ-040 No cork: rolhas_linha=0 when sensor_nivel rises -> WAIT_CORK, alarme_sem_rolha=1, no done; rolhas_linha=15 -> CAP, then done.
REQ-041 Fill timeout: sensor_nivel never rises -> FAULT reached exactly 50 cycles after FILL entry, erro=1; ack_erro -> IDLE with erro=0.
REQ-042 Stop mid-bottle: stop in FILL -> bottle completes, done pulses once, FSM enters IDLE, not MOVE; stop in MOVE -> IDLE next cycle.
REQ-043 Saturation and simultaneity: 256 completed bottles -> garrafas_ok holds at 255; start with stop in IDLE -> stays IDLE; sensor_nivel in the timeout cycle -> CAP.
REQ-044 Async reset asserted in CAP -> all outputs 0 immediately, no done pulse, garrafas_ok=0.
